// File: rtl/vp_bus_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : vp_bus_if
// Description : VProc node bus bundle (address, request strobes, data both
//               ways, acknowledges and the interrupt line).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface vp_bus_if;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        WRAck;
    logic        RDAck;
    logic        Irq;

    modport master (
        output Addr, WE, RD, WrData,
        input  RdData, WRAck, RDAck, Irq
    );

    modport slave (
        input  Addr, WE, RD, WrData,
        output RdData, WRAck, RDAck, Irq
    );
endinterface
`default_nettype wire

// File: rtl/vp_bus_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : vp_bus_responder
// Description : Memory-mapped target for the VProc node bus. Word memory,
//               control page with programmable wait states and a periodic
//               timer driving an interrupt line.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module vp_bus_responder #(
    parameter int                    ADDR_WIDTH   = 10,
    parameter logic [3:0]            MEM_SEG      = 4'ha,
    parameter logic [3:0]            CTRL_SEG     = 4'hc,
    parameter int                    WAIT_WIDTH   = 4,
    parameter logic [WAIT_WIDTH-1:0] DEFAULT_WAIT = '0
) (
    input  wire logic clk,
    input  wire logic nreset,
    vp_bus_if.slave   bus
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_WAIT    = 2'd1;
    localparam logic [1:0]  c_ACK     = 2'd2;
    localparam logic [1:0]  c_RECOVER = 2'd3;
    localparam logic [31:0] c_ID      = 32'h5650_5253;
    localparam int          c_DEPTH   = 1 << ADDR_WIDTH;

    logic [1:0]            r_state;
    logic                  r_is_wr;
    logic [3:0]            r_seg;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [WAIT_WIDTH-1:0] r_cnt;
    logic [WAIT_WIDTH-1:0] r_wait;
    logic [15:0]           r_load;
    logic [15:0]           r_count;
    logic                  r_pending;
    logic [31:0]           r_rdata;
    logic                  r_wrack;
    logic                  r_rdack;
    logic [31:0]           r_mem [0:c_DEPTH-1];

    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic        w_mem_sel;
    logic        w_ctrl_sel;
    logic [1:0]  w_reg;
    logic        w_wr_wait;
    logic        w_wr_load;
    logic        w_wr_clear;
    logic        w_expire;
    logic [31:0] w_rd_val;
    logic        w_unused_addr;

    // Address bits between the register/word index and the segment alias.
    assign w_unused_addr = ^bus.Addr[27:ADDR_WIDTH];

    assign w_req      = bus.WE | bus.RD;
    assign w_wr       = (r_state == c_ACK) &  r_is_wr;
    assign w_rd       = (r_state == c_ACK) & ~r_is_wr;
    assign w_mem_sel  = (r_seg == MEM_SEG);
    assign w_ctrl_sel = (r_seg == CTRL_SEG);
    assign w_reg      = r_idx[1:0];
    assign w_wr_wait  = w_wr & w_ctrl_sel & (w_reg == 2'd0);
    assign w_wr_load  = w_wr & w_ctrl_sel & (w_reg == 2'd1);
    assign w_wr_clear = w_wr & w_ctrl_sel & (w_reg == 2'd2) & r_wdata[0];
    assign w_expire   = (r_count == 16'd1);

    assign bus.RdData = r_rdata;
    assign bus.WRAck  = r_wrack;
    assign bus.RDAck  = r_rdack;
    assign bus.Irq    = r_pending;

    // Read-data selection from the latched address; unmapped segments give 0.
    always_comb begin
        w_rd_val = '0;
        if (w_mem_sel) begin
            w_rd_val = r_mem[r_idx];
        end else if (w_ctrl_sel) begin
            case (w_reg)
                2'd0:    w_rd_val[WAIT_WIDTH-1:0] = r_wait;
                2'd1:    w_rd_val[15:0]           = r_load;
                2'd2:    w_rd_val[0]              = r_pending;
                default: w_rd_val                 = c_ID;
            endcase
        end
    end

    // Handshake FSM: latch request, count wait states, acknowledge, then
    // wait for the master to drop its request before accepting another.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= c_IDLE;
            r_is_wr <= 1'b0;
            r_seg   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_is_wr <= bus.WE;
                        r_seg   <= bus.Addr[31:28];
                        r_idx   <= bus.Addr[ADDR_WIDTH-1:0];
                        r_wdata <= bus.WrData;
                        r_cnt   <= r_wait;
                        r_state <= (r_wait != '0) ? c_WAIT : c_ACK;
                    end
                end
                c_WAIT: begin
                    r_cnt <= r_cnt - WAIT_WIDTH'(1);
                    if (r_cnt == WAIT_WIDTH'(1)) begin
                        r_state <= c_ACK;
                    end
                end
                c_ACK: begin
                    r_state <= c_RECOVER;
                end
                c_RECOVER: begin
                    if (!w_req) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Single-cycle acknowledges and read data captured alongside them.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wrack <= 1'b0;
            r_rdack <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_wrack <= w_wr;
            r_rdack <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // Wait-state register; a new value applies from the next request.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wait <= DEFAULT_WAIT;
        end else if (w_wr_wait) begin
            r_wait <= r_wdata[WAIT_WIDTH-1:0];
        end
    end

    // Periodic timer: a load write overrides reload, expiry beats a clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_load    <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wr_load) begin
                r_load  <= r_wdata[15:0];
                r_count <= r_wdata[15:0];
            end else if (w_expire) begin
                r_count <= r_load;
            end else if (r_count != 16'd0) begin
                r_count <= r_count - 16'd1;
            end

            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (w_wr_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Word memory commit; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr && w_mem_sel) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vp_bus_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_vp_bus_responder
// Description : Self-checking bench for vp_bus_responder with a behavioural
//               model of memory, wait states and timer expiry times.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_vp_bus_responder;

    localparam int ADDR_WIDTH   = 10;
    localparam int WAIT_WIDTH   = 4;
    localparam int DEFAULT_WAIT = 0;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    vp_bus_if bus();

    vp_bus_responder #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .MEM_SEG      (4'ha),
        .CTRL_SEG     (4'hc),
        .WAIT_WIDTH   (WAIT_WIDTH),
        .DEFAULT_WAIT (4'(DEFAULT_WAIT))
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mem_m [int];
    int          wait_m = DEFAULT_WAIT;

    // Results of the last bus transfer
    logic [31:0] x_rdata;
    int          x_lat;
    int          x_edge;
    logic        x_wrack;
    logic        x_rdack;
    int          x_extra;
    logic        x_irq;

    // Bus driver: request at a falling edge, wait for an ack, optionally hold
    // the request for extra cycles, then release. Latency counts rising edges
    // after the sampling edge; x_extra counts acks seen after the first one.
    task automatic xfer(input bit we, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
        int n_edge;
        bit got;
        @(negedge clk);
        bus.Addr   = addr;
        bus.WE     = we;
        bus.RD     = rd;
        bus.WrData = wdata;
        @(posedge clk); #1;
        n_edge  = cyc;
        got     = 1'b0;
        x_lat   = -1;
        x_edge  = -1;
        x_wrack = 1'b0;
        x_rdack = 1'b0;
        x_extra = 0;
        x_irq   = 1'b0;
        x_rdata = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.WRAck || bus.RDAck) begin
                got     = 1'b1;
                x_lat   = cyc - n_edge;
                x_edge  = cyc;
                x_wrack = bus.WRAck;
                x_rdack = bus.RDAck;
                x_rdata = bus.RdData;
                x_irq   = bus.Irq;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.WRAck || bus.RDAck) x_extra++;
        end
        bus.WE = 1'b0;
        bus.RD = 1'b0;
        @(posedge clk); #1;
        if (bus.WRAck || bus.RDAck) x_extra++;
    endtask

    task automatic set_wait(input int w);
        xfer(1'b1, 1'b0, 32'hc000_0000, 32'(w), 0);
        wait_m = w;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.WRAck !== 1'b0) begin n_fail++; $display("FAIL reset_wrack: got %b expected 0", bus.WRAck); end
        n_checks++; if (bus.RDAck !== 1'b0) begin n_fail++; $display("FAIL reset_rdack: got %b expected 0", bus.RDAck); end
        n_checks++; if (bus.RdData !== 32'h0) begin n_fail++; $display("FAIL reset_rddata: got %h expected 0", bus.RdData); end
        n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.Irq); end
        @(negedge clk);
        nreset = 1'b1;
        xfer(1'b0, 1'b1, 32'hc000_0000, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'(DEFAULT_WAIT)) begin n_fail++; $display("FAIL reset_wait_reg: got %h expected %h", x_rdata, DEFAULT_WAIT); end
    endtask

    task automatic test_basic_mem();
        xfer(1'b1, 1'b0, 32'ha000_0005, 32'h1234_5678, 0);
        mem_m[5] = 32'h1234_5678;
        n_checks++; if ({x_wrack, x_rdack} !== 2'b10) begin n_fail++; $display("FAIL basic_wr_kind: got %b expected 10", {x_wrack, x_rdack}); end
        n_checks++; if (x_lat !== 1) begin n_fail++; $display("FAIL basic_wr_latency: got %0d expected 1", x_lat); end
        n_checks++; if (x_extra !== 0) begin n_fail++; $display("FAIL basic_wr_pulse: got %0d extra acks expected 0", x_extra); end
        xfer(1'b0, 1'b1, 32'ha000_0005, 32'h0, 0);
        n_checks++; if ({x_wrack, x_rdack} !== 2'b01) begin n_fail++; $display("FAIL basic_rd_kind: got %b expected 01", {x_wrack, x_rdack}); end
        n_checks++; if (x_lat !== 1) begin n_fail++; $display("FAIL basic_rd_latency: got %0d expected 1", x_lat); end
        n_checks++; if (x_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_rd_data: got %h expected 12345678", x_rdata); end
    endtask

    task automatic test_wait_states();
        set_wait(3);
        xfer(1'b0, 1'b1, 32'ha000_0005, 32'h0, 2);
        n_checks++; if (x_lat !== 4) begin n_fail++; $display("FAIL wait3_latency: got %0d expected 4", x_lat); end
        n_checks++; if (x_extra !== 0) begin n_fail++; $display("FAIL wait3_hold_reack: got %0d extra acks expected 0", x_extra); end
        n_checks++; if (x_rdata !== mem_m[5]) begin n_fail++; $display("FAIL wait3_rd_data: got %h expected %h", x_rdata, mem_m[5]); end
        xfer(1'b1, 1'b0, 32'hc000_0000, 32'hffff_fff2, 0);
        n_checks++; if (x_lat !== 4) begin n_fail++; $display("FAIL wait_wr_old_latency: got %0d expected 4", x_lat); end
        wait_m = 2;
        xfer(1'b0, 1'b1, 32'hc000_0000, 32'h0, 0);
        n_checks++; if (x_lat !== 3) begin n_fail++; $display("FAIL wait_new_latency: got %0d expected 3", x_lat); end
        n_checks++; if (x_rdata !== 32'h2) begin n_fail++; $display("FAIL wait_readback: got %h expected 2", x_rdata); end
    endtask

    task automatic test_random_mem();
        int idx;
        logic [17:0] alias_bits;
        logic [31:0] addr;
        logic [31:0] data;
        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 0) set_wait($urandom_range(0, 4));
            idx        = 37 * $urandom_range(0, 7);
            alias_bits = 18'($urandom);
            addr       = {4'ha, alias_bits, 10'(idx)};
            if (!mem_m.exists(idx) || $urandom_range(0, 1) == 1) begin
                data = $urandom;
                xfer(1'b1, ($urandom_range(0, 3) == 0), addr, data, $urandom_range(0, 2));
                mem_m[idx] = data;
                n_checks++; if ({x_wrack, x_rdack} !== 2'b10) begin n_fail++; $display("FAIL rand_wr_kind: got %b expected 10", {x_wrack, x_rdack}); end
                n_checks++; if (x_lat !== wait_m + 1) begin n_fail++; $display("FAIL rand_wr_latency: got %0d expected %0d", x_lat, wait_m + 1); end
                n_checks++; if (x_extra !== 0) begin n_fail++; $display("FAIL rand_wr_pulse: got %0d extra acks expected 0", x_extra); end
            end else begin
                xfer(1'b0, 1'b1, addr, 32'h0, $urandom_range(0, 2));
                n_checks++; if ({x_wrack, x_rdack} !== 2'b01) begin n_fail++; $display("FAIL rand_rd_kind: got %b expected 01", {x_wrack, x_rdack}); end
                n_checks++; if (x_lat !== wait_m + 1) begin n_fail++; $display("FAIL rand_rd_latency: got %0d expected %0d", x_lat, wait_m + 1); end
                n_checks++; if (x_extra !== 0) begin n_fail++; $display("FAIL rand_rd_pulse: got %0d extra acks expected 0", x_extra); end
                n_checks++; if (x_rdata !== mem_m[idx]) begin n_fail++; $display("FAIL rand_rd_data @%0d: got %h expected %h", idx, x_rdata, mem_m[idx]); end
            end
        end
    endtask

    task automatic test_ctrl_unmapped();
        set_wait(3);
        xfer(1'b0, 1'b1, 32'hc000_0003, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'h5650_5253) begin n_fail++; $display("FAIL id_read: got %h expected 56505253", x_rdata); end
        xfer(1'b0, 1'b1, 32'hb000_0000, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd_data: got %h expected 0", x_rdata); end
        n_checks++; if (x_lat !== 4) begin n_fail++; $display("FAIL unmapped_rd_latency: got %0d expected 4", x_lat); end
        xfer(1'b1, 1'b0, 32'ha000_0010, 32'h0bad_cafe, 0);
        mem_m[16] = 32'h0bad_cafe;
        xfer(1'b1, 1'b0, 32'hb000_0010, 32'hffff_ffff, 0);
        n_checks++; if ({x_wrack, x_rdack} !== 2'b10) begin n_fail++; $display("FAIL unmapped_wr_ack: got %b expected 10", {x_wrack, x_rdack}); end
        xfer(1'b0, 1'b1, 32'ha000_0010, 32'h0, 0);
        n_checks++; if (x_rdata !== mem_m[16]) begin n_fail++; $display("FAIL unmapped_wr_discard: got %h expected %h", x_rdata, mem_m[16]); end
        xfer(1'b1, 1'b0, 32'hc000_0001, 32'h1234_0000, 0);
        xfer(1'b0, 1'b1, 32'hc000_0001, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'h0) begin n_fail++; $display("FAIL load_upper_masked: got %h expected 0", x_rdata); end
        set_wait(0);
    endtask

    task automatic test_timer();
        int  L, E, C, X;
        bit  exp_irq;
        logic bad;
        L = $urandom_range(4, 8);
        xfer(1'b1, 1'b0, 32'hc000_0001, 32'(L), 0);
        E = x_edge;
        n_checks++; if (x_lat !== 1) begin n_fail++; $display("FAIL timer_load_latency: got %0d expected 1", x_lat); end
        while (cyc <= E + L) begin
            exp_irq = (cyc >= E + L);
            n_checks++; if (bus.Irq !== exp_irq) begin n_fail++; $display("FAIL timer_first_expiry @%0d: got %b expected %b", cyc - E, bus.Irq, exp_irq); end
            @(posedge clk); #1;
        end
        xfer(1'b0, 1'b1, 32'hc000_0001, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'(L)) begin n_fail++; $display("FAIL timer_load_readback: got %h expected %h", x_rdata, L); end
        xfer(1'b0, 1'b1, 32'hc000_0002, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'h1) begin n_fail++; $display("FAIL status_pending: got %h expected 1", x_rdata); end
        xfer(1'b1, 1'b0, 32'hc000_0002, 32'h1, 0);
        C = x_edge;
        exp_irq = ((C - E) % L == 0);
        n_checks++; if (x_irq !== exp_irq) begin n_fail++; $display("FAIL status_clear: got %b expected %b", x_irq, exp_irq); end
        X = E + L * ((C - E) / L + 1);
        while (cyc <= X) begin
            exp_irq = ((C - E) % L == 0) || (cyc >= X);
            n_checks++; if (bus.Irq !== exp_irq) begin n_fail++; $display("FAIL timer_reload @%0d: got %b expected %b", cyc - E, bus.Irq, exp_irq); end
            @(posedge clk); #1;
        end
        xfer(1'b1, 1'b0, 32'hc000_0001, 32'h0, 0);
        xfer(1'b1, 1'b0, 32'hc000_0002, 32'h1, 0);
        bad = 1'b0;
        repeat (3 * L) begin
            if (bus.Irq !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL timer_stopped: got irq activity expected none"); end
    endtask

    task automatic test_clear_race();
        int L, E, target;
        L = $urandom_range(4, 8);
        xfer(1'b1, 1'b0, 32'hc000_0001, 32'(L), 0);
        E      = x_edge;
        target = E + 2 * L;
        while (cyc < target - 2) begin
            @(posedge clk); #1;
        end
        xfer(1'b1, 1'b0, 32'hc000_0002, 32'h1, 0);
        n_checks++; if (x_edge !== target) begin n_fail++; $display("FAIL race_alignment: got edge %0d expected %0d", x_edge, target); end
        n_checks++; if (x_irq !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b expected 1", x_irq); end
        n_checks++; if (bus.Irq !== 1'b1) begin n_fail++; $display("FAIL race_pending_held: got %b expected 1", bus.Irq); end
        xfer(1'b1, 1'b0, 32'hc000_0001, 32'h0, 0);
        xfer(1'b1, 1'b0, 32'hc000_0002, 32'h1, 0);
        n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL race_final_clear: got %b expected 0", bus.Irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        bad;
        v = $urandom | 32'h1;
        xfer(1'b1, 1'b0, 32'ha000_0010, v, 0);
        mem_m[16] = v;
        xfer(1'b1, 1'b0, 32'hc000_0001, 32'h3, 0);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (bus.Irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", bus.Irq); end
        set_wait(3);
        xfer(1'b0, 1'b1, 32'ha000_0010, 32'h0, 0);
        @(negedge clk);
        bus.Addr   = 32'ha000_0010;
        bus.WrData = 32'hdead_beef;
        bus.WE     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b0;
        bus.WE = 1'b0;
        #1;
        n_checks++; if (bus.RdData !== 32'h0) begin n_fail++; $display("FAIL midreset_rddata: got %h expected 0", bus.RdData); end
        n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", bus.Irq); end
        #1;
        nreset = 1'b1;
        wait_m = DEFAULT_WAIT;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.WRAck !== 1'b0 || bus.RDAck !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ack: got ack expected none"); end
        xfer(1'b0, 1'b1, 32'hc000_0000, 32'h0, 0);
        n_checks++; if (x_rdata !== 32'(DEFAULT_WAIT)) begin n_fail++; $display("FAIL midreset_wait: got %h expected %h", x_rdata, DEFAULT_WAIT); end
        n_checks++; if (x_lat !== DEFAULT_WAIT + 1) begin n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", x_lat, DEFAULT_WAIT + 1); end
        xfer(1'b0, 1'b1, 32'ha000_0010, 32'h0, 0);
        n_checks++; if (x_rdata !== mem_m[16]) begin n_fail++; $display("FAIL midreset_mem_kept: got %h expected %h", x_rdata, mem_m[16]); end
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL midreset_timer_stopped: got %b expected 0", bus.Irq); end
    endtask

    initial begin
        bus.Addr   = 32'h0;
        bus.WE     = 1'b0;
        bus.RD     = 1'b0;
        bus.WrData = 32'h0;
        test_reset();
        test_basic_mem();
        test_wait_states();
        test_random_mem();
        test_ctrl_unmapped();
        test_timer();
        test_clear_race();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
